// File: rtl/dmux_stream.sv
// dmux_stream: registered valid/ready 1-to-NCH demultiplexer with broadcast.
// Each channel owns a one-entry output register; out-of-range words are dropped.
module dmux_stream #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SEL_W = $clog2(NCH),
  parameter int CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_data_i,
  input  logic [SEL_W-1:0]     in_sel_i,
  input  logic                 in_bcast_i,
  output logic [NCH-1:0]       out_valid_o,
  input  logic [NCH-1:0]       out_ready_i,
  output logic [NCH*WIDTH-1:0] out_data_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     drop_cnt_o
);

  logic [NCH-1:0]            vld_q, vld_d;
  logic [NCH-1:0][WIDTH-1:0] dat_q, dat_d;
  logic                      err_q, err_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [NCH-1:0] free;
  logic [NCH-1:0] load;
  logic           in_range;
  logic           sel_free;
  logic           xfer;
  logic           drop;

  // Handshake: a channel is free if empty or draining this cycle.
  always_comb begin
    free     = ~vld_q | out_ready_i;
    in_range = {1'b0, in_sel_i} < (SEL_W+1)'(NCH);
    sel_free = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (in_sel_i == SEL_W'(k)) begin
        sel_free = free[k];
      end
    end
    if (in_bcast_i) begin
      in_ready_o = &free;
    end else if (in_range) begin
      in_ready_o = sel_free;
    end else begin
      in_ready_o = 1'b1;
    end
    xfer = in_valid_i & in_ready_o;
    drop = xfer & ~in_bcast_i & ~in_range;
  end

  // Next state: a load beats a drain so a busy channel never bubbles.
  always_comb begin
    load  = '0;
    vld_d = vld_q;
    dat_d = dat_q;
    for (int k = 0; k < NCH; k++) begin
      load[k] = xfer &
        (in_bcast_i | (in_range & (in_sel_i == SEL_W'(k))));
      vld_d[k] = load[k] | (vld_q[k] & ~out_ready_i[k]);
      if (load[k]) begin
        dat_d[k] = in_data_i;
      end
    end
    err_d = drop;
    cnt_d = cnt_q;
    if (drop && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards any held words.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      dat_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid_o = vld_q;
  assign out_data_o  = dat_q;
  assign err_o       = err_q;
  assign drop_cnt_o  = cnt_q;

endmodule

// File: tb/tb_dmux_stream.sv
// tb_dmux_stream: directed bench with per-channel scoreboard queues.
// Main DUT is 16x4; a second NCH=3/CNT_W=2 DUT covers drops.
module tb_dmux_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, ir, ibc, err;
  logic [15:0] idata;
  logic [1:0]  isel;
  logic [3:0]  ov, ordy;
  logic [63:0] odata;
  logic [7:0]  dcnt;

  logic        iv3, ir3, err3;
  logic [15:0] idata3;
  logic [1:0]  isel3;
  logic [2:0]  ov3, ordy3;
  logic [47:0] odata3;
  logic [1:0]  dcnt3;

  int errors = 0;
  int checks = 0;
  logic [15:0] sbq [4][$];

  always #5 clk = ~clk;

  dmux_stream #(.WIDTH(16), .NCH(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(iv), .in_ready_o(ir),
    .in_data_i(idata), .in_sel_i(isel), .in_bcast_i(ibc),
    .out_valid_o(ov), .out_ready_i(ordy), .out_data_o(odata),
    .err_o(err), .drop_cnt_o(dcnt)
  );

  dmux_stream #(.WIDTH(16), .NCH(3), .CNT_W(2)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(iv3), .in_ready_o(ir3),
    .in_data_i(idata3), .in_sel_i(isel3), .in_bcast_i(1'b0),
    .out_valid_o(ov3), .out_ready_i(ordy3), .out_data_o(odata3),
    .err_o(err3), .drop_cnt_o(dcnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observe handshakes just before the edge, then advance one cycle.
  task automatic tick();
    logic [15:0] e;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (ov[k] && ordy[k]) begin
        chk($sformatf("sb_nonempty ch%0d", k), 32'(sbq[k].size() > 0), 1);
        if (sbq[k].size() > 0) begin
          e = sbq[k].pop_front();
          chk($sformatf("drain ch%0d", k), 32'(odata[k*16 +: 16]), 32'(e));
        end
      end
    end
    if (iv && ir) begin
      if (ibc) begin
        for (int k = 0; k < 4; k++) sbq[k].push_back(idata);
      end else begin
        sbq[isel].push_back(idata);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iv = 0; ibc = 0; idata = 0; isel = 0; ordy = 4'hF;
    iv3 = 0; idata3 = 0; isel3 = 0; ordy3 = 3'b111;
    @(posedge clk); @(negedge clk);
    chk("rst ov", 32'(ov), 0);
    chk("rst odata", odata[31:0] | odata[63:32], 0);
    chk("rst err", 32'(err), 0);
    chk("rst dcnt", 32'(dcnt), 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("idle ov", 32'(ov), 0);

    // Unicast to each channel on consecutive cycles
    for (int k = 0; k < 4; k++) begin
      iv = 1; isel = 2'(k); idata = 16'hA000 + 16'(k);
      #1 chk($sformatf("uni ready%0d", k), 32'(ir), 1);
      tick();
      chk($sformatf("uni valid%0d", k), 32'(ov[k]), 1);
      chk($sformatf("uni data%0d", k), 32'(odata[k*16 +: 16]),
          32'(16'hA000 + 16'(k)));
    end
    iv = 0;
    tick();
    chk("uni drained", 32'(ov), 0);
    chk("uni err", 32'(err), 0);

    // Back-to-back words to one channel, no bubble
    for (int i = 0; i < 3; i++) begin
      iv = 1; isel = 1; idata = 16'h0C00 + 16'(i);
      tick();
      chk("b2b valid", 32'(ov), 32'h2);
    end
    iv = 0;
    tick();

    // Backpressure isolation on ch2
    ordy = 4'b1011;
    iv = 1; isel = 2; idata = 16'h1111;
    tick();
    idata = 16'h2222;
    #1 chk("bp stall ready", 32'(ir), 0);
    tick();
    chk("bp hold valid", 32'(ov[2]), 1);
    chk("bp hold data", 32'(odata[47:32]), 32'h1111);
    isel = 0; idata = 16'h3333;
    #1 chk("bp ch0 ready", 32'(ir), 1);
    tick();
    chk("bp ch0 data", 32'(odata[15:0]), 32'h3333);
    isel = 2; idata = 16'h2222; ordy = 4'hF;
    #1 chk("bp release ready", 32'(ir), 1);
    tick();
    chk("bp new valid", 32'(ov[2]), 1);
    chk("bp new data", 32'(odata[47:32]), 32'h2222);
    iv = 0;
    tick();

    // Broadcast waits for stalled ch2
    ordy = 4'b1011;
    iv = 1; isel = 2; idata = 16'h4444;
    tick();
    ibc = 1; idata = 16'hBEEF;
    #1 chk("bc blocked", 32'(ir), 0);
    tick();
    chk("bc no partial", 32'(ov), 32'h4);
    ordy = 4'hF;
    #1 chk("bc ready", 32'(ir), 1);
    tick();
    chk("bc all valid", 32'(ov), 32'hF);
    for (int k = 0; k < 4; k++)
      chk($sformatf("bc data%0d", k), 32'(odata[k*16 +: 16]), 32'hBEEF);
    iv = 0; ibc = 0;
    tick();
    chk("bc drained", 32'(ov), 0);

    // Out-of-range drops on NCH=3, saturating 2-bit counter
    for (int i = 0; i < 5; i++) begin
      iv3 = 1; isel3 = 3; idata3 = 16'h0D00 + 16'(i);
      #1 chk("oor ready", 32'(ir3), 1);
      tick();
      iv3 = 0;
      chk("oor err pulse", 32'(err3), 1);
      chk("oor no valid", 32'(ov3), 0);
      chk("oor count", 32'(dcnt3), (i < 3) ? i + 1 : 3);
      tick();
      chk("oor err low", 32'(err3), 0);
    end
    iv3 = 1; isel3 = 1; idata3 = 16'h7777;
    tick();
    iv3 = 0;
    chk("n3 ch1 valid", 32'(ov3), 32'h2);
    chk("n3 ch1 data", 32'(odata3[31:16]), 32'h7777);
    chk("n3 no err", 32'(err3), 0);

    // Asynchronous reset with ch1 stalled
    ordy = 4'b1101;
    iv = 1; isel = 1; idata = 16'h5555;
    tick();
    iv = 0;
    chk("mid ch1 held", 32'(ov), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("async ov", 32'(ov), 0);
    chk("async odata", odata[31:0] | odata[63:32], 0);
    chk("async dcnt", 32'(dcnt3), 0);
    for (int k = 0; k < 4; k++) sbq[k].delete();
    @(negedge clk);
    rst = 1'b0; ordy = 4'hF;
    iv = 1; isel = 1; idata = 16'h6666;
    tick();
    iv = 0;
    chk("post rst valid", 32'(ov), 32'h2);
    chk("post rst data", 32'(odata[31:16]), 32'h6666);
    tick();
    for (int k = 0; k < 4; k++)
      chk($sformatf("sb empty%0d", k), 32'(sbq[k].size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmux_stream.md
# dmux_stream

Registered, flow-controlled N-way demultiplexer for the datapath: routes a WIDTH-bit word from one valid/ready input stream to one of NCH output streams, or broadcasts it to all of them. Each output channel has a one-entry output register, so a stalled consumer only blocks words addressed to it. Out-of-range selects are consumed, flagged and counted. It generalises the combinational 1-bit, 4-way demultiplexer to arbitrary width, channel count and handshaked streaming.

## Interface
Parameters:
- WIDTH, 16, data word width (>=1)
- NCH, 4, number of output channels (>=2, need not be a power of two)
- SEL_W, $clog2(NCH), select width (derived; not overridden)
- CNT_W, 8, width of the drop counter

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  input can accept this cycle
- in_data_i  in  WIDTH  input word
- in_sel_i  in  SEL_W  destination channel (unicast)
- in_bcast_i  in  1  1 = broadcast to all channels, in_sel_i ignored
- out_valid_o  out  NCH  per-channel output valid
- out_ready_i  in  NCH  per-channel consumer ready
- out_data_o  out  NCH*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
- err_o  out  1  one-cycle pulse after an out-of-range word is accepted
- drop_cnt_o  out  CNT_W  saturating count of discarded words

## Operation
- Per channel k: register vld[k] and dat[k]. Channel k is "free" when !vld[k] | out_ready_i[k].
- Input handshake: a word transfers on a rising edge where in_valid_i & in_ready_o.
- in_ready_o (combinational, no dependency on in_valid_i):
  - in_bcast_i=1: AND of free over all NCH channels.
  - in_bcast_i=0, in_sel_i < NCH: free[in_sel_i].
  - in_bcast_i=0, in_sel_i >= NCH: 1.
- On transfer:
  - Unicast, in range: dat[sel] <= in_data_i, vld[sel] <= 1.
  - Broadcast: all dat[k] <= in_data_i, all vld[k] <= 1.
  - Out of range: no channel is written. err_o <= 1 next cycle. drop_cnt_o increments and holds at 2^CNT_W-1.
- Output drain: vld[k] clears on out_valid_o[k] & out_ready_i[k], unless the same edge loads channel k. A load takes priority and leaves vld[k]=1, giving full throughput.
- out_data_o holds its value while out_valid_o[k]=1 & !out_ready_i[k]. dat[k] is not cleared on drain.
- err_o is 0 in any cycle not immediately after an out-of-range transfer.

## Timing
- Reset (async assert, takes effect immediately): out_valid_o=0, out_data_o=0, err_o=0, drop_cnt_o=0. Reset takes effect mid-operation too, and held words are lost.
- in_ready_o may be 1 during reset. Transfers are ignored while rst_i=1.
- Latency: 1 cycle. A word accepted at edge n is visible on out_valid_o/out_data_o after edge n.
- Throughput: 1 word/cycle per channel while the consumer holds out_ready_i=1.
- Interleaved destinations sustain 1 word/cycle aggregate.
- A broadcast waits until every channel is free. A partial broadcast never occurs.
- in_ready_o depends combinationally on out_ready_i. out_valid_o and out_data_o are registered only.
- Simultaneous drain and load on the same channel: the new word appears, valid stays high, and there is no bubble.
- Changing in_sel_i, in_bcast_i or in_data_i while in_valid_i & !in_ready_o is legal. The stream is evaluated every cycle.
- drop_cnt_o updates on the edge of the out-of-range transfer, the same edge on which err_o rises.

## Test plan
- Reset then idle: after rst_i pulse, all outputs 0. in_valid_i=0 for 10 cycles gives out_valid_o=0.
- Unicast routing, WIDTH=16, NCH=4, all out_ready_i=1: send 0xA000+k to sel=k for k=0..3 on consecutive cycles. Expected: each channel k shows 0xA000+k exactly one cycle after acceptance, with in_ready_o=1 throughout.
- Backpressure isolation: hold out_ready_i[2]=0 and send 0x1111 then 0x2222 to sel=2. Expected: in_ready_o=0 for the second word while ch2 holds 0x1111. A word to sel=0 is still accepted. Releasing out_ready_i[2] admits 0x2222 on that same edge.
- Broadcast: out_ready_i=4'b1011 with ch2 full, send 0xBEEF with in_bcast_i=1. Expected: in_ready_o=0 until ch2 drains, then all four channels show 0xBEEF in the same cycle.
- Out of range, NCH=3 (SEL_W=2): send sel=3 three times. Expected: in_ready_o=1, no out_valid_o change, three err_o pulses, drop_cnt_o=3. With CNT_W=2, five drops saturate at 3.
- Reset mid-stream: assert rst_i with ch1 valid and stalled. Expected: out_valid_o=0 immediately (asynchronous), drop_cnt_o=0, and normal operation on release.
